// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared, combinational-input ALU.
// Grants round-robin on contention, waits MOD_LATENCY cycles for MOD, and returns one response pulse per operation.
module alu_arbiter #(
    parameter int MOD_LATENCY = 34
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_A,
    input  logic [31:0] req0_B,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_A,
    input  logic [31:0] req1_B,
    input  logic [2:0]  req1_op,
    output logic [31:0] alu_A,
    output logic [31:0] alu_B,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_result,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

    localparam logic [2:0] OP_MOD = 3'b111;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic        id_q, id_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic        grant0, grant1, alu_drive;

    // On contention the requester that was not served last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE && !reset) begin
            grant0 = req0_valid && (!req1_valid || last_grant_q);
            grant1 = req1_valid && (!req0_valid || !last_grant_q);
        end
    end

    always_comb begin
        // NOTE: every _d takes its held value first, so no path through the case can infer a latch.
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    a_d          = grant1 ? req1_A  : req0_A;
                    b_d          = grant1 ? req1_B  : req0_B;
                    op_d         = grant1 ? req1_op : req0_op;
                    id_d         = grant1;
                    last_grant_d = grant1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                if (op_q == OP_MOD) begin
                    cnt_d   = 8'(MOD_LATENCY);
                    state_d = WAIT;
                end else begin
                    rsp_result_d = alu_result;
                    rsp_id_d     = id_q;
                    state_d      = RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    rsp_result_d = alu_result;
                    rsp_id_d     = id_q;
                    state_d      = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with <= only so every flop samples pre-edge values.
        if (reset) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    // Operands are zeroed outside EXEC/WAIT so the ALU's MOD unit restarts on every MOD.
    assign alu_drive  = (state_q == EXEC || state_q == WAIT) && !reset;
    assign alu_A      = alu_drive ? a_q  : 32'd0;
    assign alu_B      = alu_drive ? b_q  : 32'd0;
    assign alu_op     = alu_drive ? op_q : 3'b000;
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign busy       = (state_q != IDLE) && !reset;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: ALU model, cycle-level transaction reference model and directed/random stimulus.
module tb_alu_arbiter;
    localparam int MOD_LAT = 34;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } op_t;

    typedef struct {
        int          due;
        logic        id;
        logic [31:0] res;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_A, req0_B, req1_A, req1_B;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] alu_A, alu_B, alu_result, rsp_result;
    logic [2:0]  alu_op;
    logic        rsp_valid, rsp_id, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mod_age = 0;

    op_t  q0[$], q1[$];
    exp_t exp_q[$];
    int   hs_cyc[$], rsp_cyc[$];
    logic hs_id[$], rsp_id_log[$];
    logic [31:0] rsp_res_log[$];

    logic        outstanding = 1'b0;
    logic        exp_last = 1'b1;
    logic        exp_rsp_id = 1'b0;
    logic [31:0] exp_rsp_res = 32'd0;
    op_t         cur;

    always #5 clk = ~clk;

    alu_arbiter #(.MOD_LATENCY(MOD_LAT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B), .req1_op(req1_op),
        .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .busy(busy)
    );

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return a << b[4:0];
            3'd4:    return (a < b) ? 32'd1 : 32'd0;
            3'd5:    return a + b;
            3'd6:    return a - b;
            default: return (b == 0) ? 32'd0 : a % b;
        endcase
    endfunction

    // Shared ALU: MOD output is garbage until the operands have been held for MOD_LAT edges.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        mod_age <= (alu_op == 3'b111) ? mod_age + 1 : 0;
    end
    assign alu_result = (alu_op == 3'b111 && mod_age < MOD_LAT) ? 32'hDEAD_BEEF : alu_fn(alu_A, alu_B, alu_op);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: one operation in flight, response due 2 (+MOD_LAT) cycles after the handshake.
    always @(negedge clk) begin
        logic resp_now, g0, g1;
        if (reset) begin
            check("rst_ready0", 32'(req0_ready), 32'd0);
            check("rst_ready1", 32'(req1_ready), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_alu_op", 32'(alu_op), 32'd0);
            exp_q.delete();
            outstanding = 1'b0;
            exp_last    = 1'b1;
            exp_rsp_id  = 1'b0;
            exp_rsp_res = 32'd0;
        end else begin
            resp_now = (exp_q.size() != 0) && (exp_q[0].due == cyc);
            if (resp_now) begin
                exp_rsp_id  = exp_q[0].id;
                exp_rsp_res = exp_q[0].res;
            end
            check("rsp_valid", 32'(rsp_valid), 32'(resp_now));
            check("rsp_id", 32'(rsp_id), 32'(exp_rsp_id));
            check("rsp_result", rsp_result, exp_rsp_res);
            check("busy", 32'(busy), 32'(outstanding));
            check("alu_op", 32'(alu_op), (outstanding && !resp_now) ? 32'(cur.op) : 32'd0);
            check("alu_A", alu_A, (outstanding && !resp_now) ? cur.a : 32'd0);
            check("alu_B", alu_B, (outstanding && !resp_now) ? cur.b : 32'd0);
            g0 = !outstanding && req0_valid && (!req1_valid || exp_last);
            g1 = !outstanding && req1_valid && (!req0_valid || !exp_last);
            check("req0_ready", 32'(req0_ready), 32'(g0));
            check("req1_ready", 32'(req1_ready), 32'(g1));
            if (rsp_valid) begin
                rsp_cyc.push_back(cyc);
                rsp_id_log.push_back(rsp_id);
                rsp_res_log.push_back(rsp_result);
            end
            if (req0_valid && req0_ready) begin hs_cyc.push_back(cyc); hs_id.push_back(1'b0); end
            if (req1_valid && req1_ready) begin hs_cyc.push_back(cyc); hs_id.push_back(1'b1); end
            if (resp_now) begin
                void'(exp_q.pop_front());
                outstanding = 1'b0;
            end else if (g0 || g1) begin
                cur.a  = g1 ? req1_A  : req0_A;
                cur.b  = g1 ? req1_B  : req0_B;
                cur.op = g1 ? req1_op : req0_op;
                exp_q.push_back('{cyc + 2 + ((cur.op == 3'b111) ? MOD_LAT : 0), g1, alu_fn(cur.a, cur.b, cur.op)});
                outstanding = 1'b1;
                exp_last    = g1;
            end
        end
    end

    // One cycle of the requester drivers: each holds valid until accepted, then presents its next queued op.
    task automatic step();
        logic hs0, hs1;
        op_t  o;
        @(negedge clk);
        hs0 = req0_valid && req0_ready;
        hs1 = req1_valid && req1_ready;
        @(posedge clk);
        #1;
        if (hs0 || !req0_valid) begin
            if (q0.size() != 0) begin
                o = q0.pop_front();
                req0_valid = 1'b1; req0_A = o.a; req0_B = o.b; req0_op = o.op;
            end else req0_valid = 1'b0;
        end
        if (hs1 || !req1_valid) begin
            if (q1.size() != 0) begin
                o = q1.pop_front();
                req1_valid = 1'b1; req1_A = o.a; req1_B = o.b; req1_op = o.op;
            end else req1_valid = 1'b0;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || req0_valid || req1_valid || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $error("FAIL drain_timeout observed=%0d cycles expected=below %0d", n, budget);
        end
    endtask

    task automatic do_reset(input int n);
        q0.delete();
        q1.delete();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int base;
        logic [2:0] rop;
        op_t o;
        reset = 1'b1;
        req0_valid = 1'b0; req0_A = '0; req0_B = '0; req0_op = '0;
        req1_valid = 1'b0; req1_A = '0; req1_B = '0; req1_op = '0;
        do_reset(3);
        step();

        // Single ADD
        base = rsp_cyc.size();
        q0.push_back('{32'd5, 32'd7, 3'b101});
        drain(50);
        check("add_id", 32'(rsp_id_log[base]), 32'd0);
        check("add_result", rsp_res_log[base], 32'd12);
        check("add_latency", 32'(rsp_cyc[base] - hs_cyc[base]), 32'd2);

        // Contention right after reset: requester 0 first
        do_reset(1);
        base = rsp_cyc.size();
        q0.push_back('{32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000});
        q1.push_back('{32'd10, 32'd3, 3'b110});
        drain(50);
        check("cont_first_id", 32'(rsp_id_log[base]), 32'd0);
        check("cont_first_res", rsp_res_log[base], 32'hF000_F000);
        check("cont_second_id", 32'(rsp_id_log[base + 1]), 32'd1);
        check("cont_second_res", rsp_res_log[base + 1], 32'd7);

        // Modulo operation on requester 1
        base = rsp_cyc.size();
        q1.push_back('{32'd17, 32'd5, 3'b111});
        drain(100);
        check("mod_result", rsp_res_log[base], 32'd2);
        check("mod_latency", 32'(rsp_cyc[base] - hs_cyc[base]), 32'(2 + MOD_LAT));

        // Less-than in both directions
        base = rsp_cyc.size();
        q0.push_back('{32'd3, 32'd9, 3'b100});
        q0.push_back('{32'd9, 32'd3, 3'b100});
        drain(50);
        check("lt_true", rsp_res_log[base], 32'd1);
        check("lt_false", rsp_res_log[base + 1], 32'd0);

        // Fairness: both continuously valid, last served was requester 0
        base = rsp_cyc.size();
        for (int i = 0; i < 5; i++) begin
            q0.push_back('{$urandom, $urandom, 3'($urandom_range(0, 6))});
            q1.push_back('{$urandom, $urandom, 3'($urandom_range(0, 6))});
        end
        drain(100);
        for (int k = 0; k < 10; k++) begin
            check("fair_id", 32'(rsp_id_log[base + k]), (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k > 0) check("fair_spacing", 32'(rsp_cyc[base + k] - rsp_cyc[base + k - 1]), 32'd3);
        end

        // Random mix, including MOD
        for (int i = 0; i < 24; i++) begin
            rop  = 3'($urandom_range(0, 7));
            o.a  = $urandom;
            o.b  = (rop == 3'b111) ? 32'($urandom_range(1, 999)) : $urandom;
            o.op = rop;
            if ($urandom_range(0, 1) == 1) q0.push_back(o);
            else q1.push_back(o);
        end
        drain(3000);

        // Reset in the 10th WAIT cycle of a requester-0 MOD, then contention goes to requester 0
        base = rsp_cyc.size();
        q0.push_back('{32'd1000, 32'd7, 3'b111});
        repeat (12) step();
        do_reset(1);
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_no_rsp", 32'(rsp_cyc.size() - base), 32'd0);
        base = hs_id.size();
        q0.push_back('{32'd2, 32'd2, 3'b101});
        q1.push_back('{32'd3, 32'd3, 3'b101});
        drain(50);
        check("post_reset_grant", 32'(hs_id[base]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: MOD_LATENCY, default 34, number of cycles the ALU needs for a MOD (ALUop 3'b111) result; legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  reset, synchronous and active-high.
REQ-004 Port: req0_valid  input  1  requester 0 has an operation pending.
REQ-005 Port: req0_ready  output  1  arbiter accepts requester 0 this cycle.
REQ-006 Port: req0_A / req0_B  input  32 each  requester 0 operands.
REQ-007 Port: req0_op  input  3  requester 0 ALU operation code.
REQ-008 Port: req1_valid, req1_ready, req1_A, req1_B, req1_op  same directions, widths and meanings as REQ-004..REQ-007, for requester 1.
REQ-009 Port: alu_A / alu_B  output  32 each  operands driven to the shared ALU.
REQ-010 Port: alu_op  output  3  operation code driven to the shared ALU.
REQ-011 Port: alu_result  input  32  ALU Result.
REQ-012 Port: rsp_valid  output  1  one-cycle pulse; response fields valid.
REQ-013 Port: rsp_id  output  1  requester that owns the response.
REQ-014 Port: rsp_result  output  32  captured ALU result.
REQ-015 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, EXEC, WAIT, RESP.
REQ-017 Grant in IDLE: only one valid -> that requester; both valid -> requester other than last_grant; none -> no grant.
REQ-018 reqN_ready SHALL be high only in IDLE and only for the granted requester; it may depend combinationally on reqN_valid.
REQ-019 Handshake (valid & ready high, rising edge): latch A, B, op, id; set last_grant = id; go to EXEC.
REQ-020 In EXEC and WAIT, alu_A/alu_B/alu_op SHALL be driven from the latched registers and SHALL stay stable.
REQ-021 In IDLE and RESP, alu_A = 0, alu_B = 0, alu_op = 3'b000, so every MOD restarts the ALU's MOD unit from scratch.
REQ-022 EXEC, op != 3'b111: capture alu_result into rsp_result at end of cycle; go to RESP.
REQ-023 EXEC, op == 3'b111: load the 8-bit counter with MOD_LATENCY; go to WAIT.
REQ-024 WAIT: decrement the counter each cycle; when the counter == 1, capture alu_result and go to RESP.
REQ-025 RESP: rsp_valid = 1 for exactly one cycle with rsp_id and rsp_result; next state is IDLE.
REQ-026 Latency, handshake at edge t: non-MOD rsp_valid in cycle t+2; MOD rsp_valid in cycle t+2+MOD_LATENCY.
REQ-027 There is no response backpressure; a requester SHALL NOT be granted again before its previous rsp_valid pulse.
REQ-028 rsp_result and rsp_id SHALL hold their last values after the pulse until the next capture.
REQ-029 Back-to-back operation: with requests pending, the next grant occurs in the IDLE cycle directly after RESP (peak: one non-MOD operation per 3 cycles).
REQ-030 Opcode 3'b100 result is passed through unmodified (0 or 1); no opcode is treated as illegal.

Reset
REQ-031 reset high at an edge SHALL force IDLE.
REQ-032 The same edge SHALL set rsp_valid = 0, rsp_id = 0, rsp_result = 0, counter = 0, latched A/B/op = 0, and last_grant = 1 (requester 0 wins the first contention).
REQ-033 While reset is high, busy, req0_ready and req1_ready SHALL be 0 and alu_op SHALL be 3'b000.
REQ-034 Reset in EXEC or WAIT SHALL abort the operation with no response pulse.

Verification
REQ-035 Single ADD: req0 A=5, B=7, op=101 accepted at t -> rsp_valid at t+2, rsp_id=0, rsp_result=12.
REQ-036 Contention after reset: both valid, req0 op=000 (A=F0F0F0F0, B=FF00FF00), req1 op=110 (A=10, B=3) -> req0 served first with result F000F000; req1 next with result 7 and rsp_id=1.
REQ-037 MOD with MOD_LATENCY=34: req1 A=17, B=5, op=111 at t -> alu_op=111 stable t+1..t+35; rsp_valid at t+36, result 2; no earlier pulse.
REQ-038 Fairness: both requesters continuously valid for 10 operations -> grants alternate 0,1,0,1,...; each rsp_valid exactly 3 cycles apart.
REQ-039 Reset mid-WAIT: MOD issued, reset at 10th WAIT cycle -> next cycle state IDLE, rsp_valid stays 0, busy=0, and the following contention grants req0.
REQ-040 LESS THAN: A=3, B=9, op=100 -> rsp_result=1; A=9, B=3 -> rsp_result=0.
